// File: rtl/imem_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_program_loader
// Purpose  : Boot-time writer for the instruction memory. Receives a framed
//            byte stream (SYNC 0xA5, LEN_LO, LEN_HI, LEN*4 data bytes, CHK),
//            packs every 4 bytes into a little-endian 32-bit instruction,
//            writes it at consecutive word addresses and keeps the core in
//            reset until a whole frame with a good checksum has landed.
// Ports    : i_clk          system clock
//            i_reset_n      asynchronous active-low reset
//            i_rx_data      stream byte
//            i_rx_valid     stream byte valid
//            o_rx_ready     loader can accept a byte
//            o_imem_we      single-cycle instruction memory write strobe
//            o_imem_addr    byte address of the write (word aligned)
//            o_imem_wdata   instruction word to write
//            o_cpu_reset_n  active-low reset to the core
//            o_load_done    sticky: frame written and checksum good
//            o_load_error   sticky: checksum mismatch or length out of range
// Revision : 1.0 - initial release
// ============================================================================
module imem_program_loader #(
    parameter int DATA_WIDTH      = 32,
    parameter int INSTR_MEM_DEPTH = 256,
    parameter int ADDR_WIDTH      = $clog2(INSTR_MEM_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_rx_ready,
    output logic                  o_imem_we,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    output logic [DATA_WIDTH-1:0] o_imem_wdata,
    output logic                  o_cpu_reset_n,
    output logic                  o_load_done,
    output logic                  o_load_error
);

    localparam logic [7:0]  c_SYNC      = 8'hA5;
    localparam int unsigned c_MAX_WORDS = INSTR_MEM_DEPTH / 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_CHECK  = 3'd5,
        S_DONE   = 3'd6,
        S_ERROR  = 3'd7
    } state_t;

    state_t                  state_q, state_d;
    logic [15:0]             len_q;
    logic [15:0]             word_cnt_q;
    logic [1:0]              byte_cnt_q;
    logic [23:0]             word_q;      // bytes 0..2 of the word being built
    logic [7:0]              chk_q;
    logic [ADDR_WIDTH-1:0]   addr_q;      // address of the next word to write
    logic                    rx_ready_q;
    logic                    imem_we_q;
    logic [ADDR_WIDTH-1:0]   imem_addr_q;
    logic [DATA_WIDTH-1:0]   imem_wdata_q;
    logic                    cpu_reset_n_q;
    logic                    load_done_q;
    logic                    load_error_q;

    logic                    w_xfer;
    logic [15:0]             w_len_full;

    assign w_xfer     = i_rx_valid & rx_ready_q;
    assign w_len_full = {i_rx_data, len_q[7:0]};

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_xfer && (i_rx_data == c_SYNC)) state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (w_xfer) state_d = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (w_xfer) begin
                    if (32'(w_len_full) > c_MAX_WORDS) state_d = S_ERROR;
                    else if (w_len_full == 16'd0)      state_d = S_CHECK;
                    else                               state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (w_xfer && (byte_cnt_q == 2'd3)) state_d = S_WRITE;
            end
            S_WRITE: begin
                if ((word_cnt_q + 16'd1) == len_q) state_d = S_CHECK;
                else                               state_d = S_DATA;
            end
            S_CHECK: begin
                if (w_xfer) state_d = (i_rx_data == chk_q) ? S_DONE : S_ERROR;
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            S_ERROR: begin
                if (w_xfer && (i_rx_data == c_SYNC)) state_d = S_LEN_LO;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q       <= S_IDLE;
            len_q         <= '0;
            word_cnt_q    <= '0;
            byte_cnt_q    <= '0;
            word_q        <= '0;
            chk_q         <= '0;
            addr_q        <= '0;
            rx_ready_q    <= 1'b1;
            imem_we_q     <= 1'b0;
            imem_addr_q   <= '0;
            imem_wdata_q  <= '0;
            cpu_reset_n_q <= 1'b0;
            load_done_q   <= 1'b0;
            load_error_q  <= 1'b0;
        end else begin
            state_q <= state_d;

            // Outputs are registered from the next state so they line up
            // with the state they describe. DONE and ERROR are only left by
            // reset or a retry, which makes done/error naturally sticky.
            rx_ready_q    <= (state_d != S_WRITE) && (state_d != S_DONE);
            imem_we_q     <= (state_d == S_WRITE);
            cpu_reset_n_q <= (state_d == S_DONE);
            load_done_q   <= (state_d == S_DONE);
            load_error_q  <= (state_d == S_ERROR);

            case (state_q)
                S_LEN_LO: begin
                    if (w_xfer) len_q[7:0] <= i_rx_data;
                end
                S_LEN_HI: begin
                    if (w_xfer) begin
                        len_q[15:8] <= i_rx_data;
                        addr_q      <= '0;
                        chk_q       <= '0;
                        byte_cnt_q  <= '0;
                        word_cnt_q  <= '0;
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        chk_q      <= chk_q ^ i_rx_data;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        case (byte_cnt_q)
                            2'd0: word_q[7:0]   <= i_rx_data;
                            2'd1: word_q[15:8]  <= i_rx_data;
                            2'd2: word_q[23:16] <= i_rx_data;
                            default: begin
                                // Last byte goes straight into the output
                                // word so the write can fire next cycle.
                                imem_addr_q  <= addr_q;
                                imem_wdata_q <= {i_rx_data, word_q};
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    addr_q     <= addr_q + ADDR_WIDTH'(4);
                    word_cnt_q <= word_cnt_q + 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_rx_ready    = rx_ready_q;
    assign o_imem_we     = imem_we_q;
    assign o_imem_addr   = imem_addr_q;
    assign o_imem_wdata  = imem_wdata_q;
    assign o_cpu_reset_n = cpu_reset_n_q;
    assign o_load_done   = load_done_q;
    assign o_load_error  = load_error_q;

endmodule
`default_nettype wire

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Writer side of the instruction memory. Receives a framed byte stream over a valid/ready interface.
- Assembles each 4 bytes into a little-endian 32-bit instruction and writes it into the instruction fetch memory at consecutive word addresses.
- Holds the CPU core in reset until a complete frame with a correct checksum has been written.
- Replaces hierarchical preloading of instruction memory with a synthesizable boot path.

Parameters:
- DATA_WIDTH, 32, instruction word width; only 32 is supported.
- INSTR_MEM_DEPTH, 256, instruction memory size in bytes; must be a power of 2. ADDR_WIDTH = $clog2(INSTR_MEM_DEPTH). Maximum frame length is INSTR_MEM_DEPTH/4 words.

Ports:
- i_clk  in  1  system clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_rx_data  in  8  stream byte.
- i_rx_valid  in  1  i_rx_data is valid.
- o_rx_ready  out  1  loader accepts a byte; a transfer occurs at posedge when valid & ready.
- o_imem_we  out  1  instruction memory write enable, single-cycle pulse.
- o_imem_addr  out  ADDR_WIDTH  byte address of the write; always a multiple of 4.
- o_imem_wdata  out  DATA_WIDTH  instruction word to write.
- o_cpu_reset_n  out  1  active-low reset to the core; low until the load succeeds.
- o_load_done  out  1  sticky, frame written and checksum good.
- o_load_error  out  1  sticky, checksum mismatch or length out of range.

Behaviour:
- Frame format: SYNC 0xA5; LEN_LO; LEN_HI (LEN = number of words, 16-bit little-endian); LEN*4 data bytes; CHK. CHK = XOR of all data bytes, or 0x00 when LEN = 0.
- Reset (async, any state): state=IDLE, o_rx_ready=1, o_imem_we=0, o_imem_addr=0, o_imem_wdata=0, o_cpu_reset_n=0, o_load_done=0, o_load_error=0; byte counter, word counter and checksum register cleared. A reset during a load abandons it; words already written are not erased.
- All outputs are registered.
- States:
  - IDLE: accepted byte 0xA5 -> LEN_LO. Any other byte is discarded; stay in IDLE.
  - LEN_LO: latch the low byte -> LEN_HI.
  - LEN_HI: latch the high byte.
    - LEN > INSTR_MEM_DEPTH/4 -> ERROR.
    - LEN = 0 -> CHECK.
    - Otherwise -> DATA, with address = 0 and checksum = 0.
  - DATA: accepted byte k (k = 0..3) goes to wdata[8k+7:8k] and is XORed into the checksum. After the 4th byte -> WRITE.
  - WRITE: exactly one cycle. o_imem_we=1 with the current address and word; o_rx_ready=0. Next cycle: address += 4, word count += 1. If the count reaches LEN -> CHECK, else -> DATA.
  - CHECK: on an accepted byte:
    - byte == checksum -> DONE; o_load_done=1 and o_cpu_reset_n=1, both on the cycle after acceptance.
    - byte != checksum -> ERROR.
  - DONE: terminal until reset. o_rx_ready=0; the stream is ignored.
  - ERROR: o_load_error=1, o_cpu_reset_n stays 0, o_rx_ready=1. Accepted 0xA5 -> LEN_LO and clears o_load_error (retry). Other bytes are discarded.
- o_rx_ready is 1 in IDLE, LEN_LO, LEN_HI, DATA, CHECK and ERROR; 0 in WRITE and DONE.
- While valid is low, no state changes; gaps of any length are allowed in every state.
- Write latency: o_imem_we is high on the cycle after the 4th byte of a word is accepted.
- Throughput: 5 cycles per word at continuous valid.
- Address: the last write of a maximum-length frame is to INSTR_MEM_DEPTH-4. The address never wraps within a frame.
- o_imem_addr and o_imem_wdata hold their values when o_imem_we=0.

Test Plan:
1. Reset, then send A5 02 00 44 33 22 11 D0 C0 B0 A0 44 with continuous valid -> exactly two we pulses: addr 0x00 / 0x11223344, then addr 0x04 / 0xA0B0C0D0. o_load_done=1 and o_cpu_reset_n=1 one cycle after CHK; o_rx_ready=0 afterwards.
2. Same frame with CHK=0x45 -> two writes occur, o_load_error=1, o_cpu_reset_n=0. Resend the correct frame -> error clears, done=1.
3. Send 00 FF 13 before A5 01 00 13 05 50 00 46 -> junk ignored; one write of addr 0 / 0x00500513; done=1.
4. Send A5 41 00 (65 words with depth 256) -> ERROR immediately, no writes. Send A5 00 00 00 -> done=1 with zero writes.
5. Deassert i_reset_n after 2 of 4 data bytes -> all outputs return to reset values asynchronously; a full frame then loads correctly from addr 0.
6. Frame of 64 words with random valid gaps -> 64 writes at addresses 0..252 step 4; data matches the byte stream; done=1.
